matrix_gram_engine: RTL and testbench

Downstream consumer of the `matrix_multiplication` read stream. It captures the `ROW_SIZE` x `COL_SIZE` words delivered on `data_out` during read phases into a local matrix A. Once A is complete, it computes the Gram product C = A·Aᵀ with one multiply-accumulate per cycle. Each of the `ROW_SIZE`² entries of C is streamed out on a valid/ready port. The block sits directly after the address/direction sequencer and feeds the result sink.

---
 rtl/matrix_gram_engine.sv | 139 +++++++++++++
 tb/tb_matrix_gram_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_gram_engine.sv
// Captures a ROW_SIZE x COL_SIZE matrix A from the upstream read stream, then
// streams out the Gram product C = A*A^T one entry at a time on a valid/ready port.
module matrix_gram_engine #(
  parameter int WORD_SIZE = 2,
  parameter int ROW_SIZE  = 2,
  parameter int COL_SIZE  = 2,
  parameter int ADDR_SIZE = ROW_SIZE * COL_SIZE,
  parameter int ACC_SIZE  = 5,
  localparam int IDX_W    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_direction,
  input  logic [ADDR_SIZE-1:0] in_addr,
  output logic [ACC_SIZE-1:0]  out_data,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);

  localparam int K_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int N   = ROW_SIZE * COL_SIZE;
  localparam logic [ADDR_SIZE:0] N_EXT  = (ADDR_SIZE + 1)'(N);
  localparam logic [IDX_W-1:0]   I_LAST = IDX_W'(ROW_SIZE - 1);
  localparam logic [K_W-1:0]     K_LAST = K_W'(COL_SIZE - 1);

  typedef enum logic [1:0] {CAPTURE, COMPUTE, OUTPUT} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] a_mem [ROW_SIZE][COL_SIZE];
  logic [N-1:0]         mask;
  logic [ACC_SIZE-1:0]  acc;
  logic [IDX_W-1:0]     i_idx;
  logic [IDX_W-1:0]     j_idx;
  logic [K_W-1:0]       k_idx;

  logic                 wr_req;
  logic [IDX_W-1:0]     wr_row;
  logic [K_W-1:0]       wr_col;
  logic [N-1:0]         mask_next;
  logic [ACC_SIZE-1:0]  acc_next;

  // NOTE: every signal gets a value on every path through this block, so no latches.
  always_comb begin
    wr_req    = in_direction && ({1'b0, in_addr} < N_EXT);
    wr_row    = IDX_W'(in_addr / ADDR_SIZE'(COL_SIZE));
    wr_col    = K_W'(in_addr % ADDR_SIZE'(COL_SIZE));
    mask_next = mask | (N'(1) << in_addr);
    acc_next  = acc + ACC_SIZE'(a_mem[i_idx][k_idx]) * ACC_SIZE'(a_mem[j_idx][k_idx]);
  end

  // NOTE: the matrix store is reset too, so a reset mid-run can never leak old
  // elements into the next product; non-blocking assignments throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CAPTURE;
      mask      <= '0;
      acc       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int r = 0; r < ROW_SIZE; r++)
        for (int c = 0; c < COL_SIZE; c++)
          a_mem[r][c] <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (wr_req) begin
            a_mem[wr_row][wr_col] <= in_data;
            if (&mask_next) begin
              mask  <= '0;
              acc   <= '0;
              i_idx <= '0;
              j_idx <= '0;
              k_idx <= '0;
              busy  <= 1'b1;
              state <= COMPUTE;
            end else begin
              mask <= mask_next;
            end
          end
        end

        COMPUTE: begin
          if (wr_req) overrun <= 1'b1;
          if (k_idx == K_LAST) begin
            out_data  <= acc_next;
            out_row   <= i_idx;
            out_col   <= j_idx;
            out_valid <= 1'b1;
            out_last  <= (i_idx == I_LAST) && (j_idx == I_LAST);
            acc       <= '0;
            k_idx     <= '0;
            state     <= OUTPUT;
          end else begin
            acc   <= acc_next;
            k_idx <= k_idx + K_W'(1);
          end
        end

        OUTPUT: begin
          if (wr_req) overrun <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // j is the inner index; i advances when j wraps.
            if (j_idx == I_LAST) begin
              j_idx <= '0;
              i_idx <= (i_idx == I_LAST) ? '0 : i_idx + IDX_W'(1);
            end else begin
              j_idx <= j_idx + IDX_W'(1);
            end
            if (out_last) begin
              busy  <= 1'b0;
              state <= CAPTURE;
            end else begin
              state <= COMPUTE;
            end
          end
        end

        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_gram_engine.sv
// Self-checking bench for matrix_gram_engine: a scoreboard queue of expected
// C entries is filled when a matrix is loaded and drained by the output monitor.
module tb_matrix_gram_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_data;
  logic       in_direction;
  logic [3:0] in_addr;
  logic [4:0] out_data;
  logic       out_row;
  logic       out_col;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       overrun;

  matrix_gram_engine dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_direction (in_direction),
    .in_addr      (in_addr),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    int last;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: C[i][j] = sum_k A[i][k]*A[j][k], j inner, last on (1,1).
  task automatic push_expected(input int m [4]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        exp_t e;
        e.data = m[i*2] * m[j*2] + m[i*2+1] * m[j*2+1];
        e.row  = i;
        e.col  = j;
        e.last = (i == 1 && j == 1) ? 1 : 0;
        sb.push_back(e);
      end
  endtask

  // Drives one input for exactly one rising edge.
  task automatic write(input logic dir, input int a, input int d);
    @(posedge clk); #1;
    in_direction = dir;
    in_addr      = 4'(a);
    in_data      = 2'(d);
  endtask

  // Loads a full matrix; returns at E0+1 with inputs idle.
  task automatic load_all(input int m [4]);
    push_expected(m);
    for (int a = 0; a < 4; a++) write(1'b1, a, m[a]);
    @(posedge clk); #1;
    in_direction = 1'b0;
    in_addr      = '0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  // Output monitor: a transfer happens on the edge after valid&ready is seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_row",  32'(out_row),  32'(e.row));
        check("out_col",  32'(out_col),  32'(e.col));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   32'(out_valid), 32'd0);
    check({tag, "_data"},    32'(out_data),  32'd0);
    check({tag, "_row"},     32'(out_row),   32'd0);
    check({tag, "_col"},     32'(out_col),   32'd0);
    check({tag, "_last"},    32'(out_last),  32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_overrun"}, 32'(overrun),   32'd0);
  endtask

  initial begin
    int  m_basic [4] = '{1, 2, 3, 0};
    int  m_max   [4] = '{3, 3, 3, 3};
    int  m_rw    [4] = '{1, 3, 3, 0};
    bit  seen;

    rst = 1'b1; in_data = '0; in_direction = 1'b0; in_addr = '0; out_ready = 1'b1;
    #3;
    check_zero_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("idle");

    // Basic product with latency and throughput checks.
    acc_cyc.delete();
    load_all(m_basic);
    check("busy_after_e0", 32'(busy), 32'd1);
    check("valid_at_e0", 32'(out_valid), 32'd0);
    @(posedge clk); #1 check("valid_at_e0p1", 32'(out_valid), 32'd0);
    @(posedge clk); #1 check("valid_at_e0p2", 32'(out_valid), 32'd1);
    repeat (9) @(posedge clk);
    #1 check("busy_at_e0p11", 32'(busy), 32'd1);
    @(posedge clk); #1 check("busy_at_e0p12", 32'(busy), 32'd0);
    check("basic_count", 32'(acc_cyc.size()), 32'd4);
    for (int n = 1; n < acc_cyc.size(); n++)
      check("entry_spacing", 32'(acc_cyc[n] - acc_cyc[n-1]), 32'd3);
    check("basic_overrun", 32'(overrun), 32'd0);
    wait_done("basic");

    // Maximum element values.
    load_all(m_max);
    wait_done("max");

    // Backpressure on entry (0,1).
    load_all(m_basic);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (out_valid && out_row == 1'b0 && out_col == 1'b0) seen = 1;
    end
    check("bp_first_valid", 32'(seen), 32'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'd3);
      check("bp_row",   32'(out_row),   32'd0);
      check("bp_col",   32'(out_col),   32'd1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    wait_done("bp");

    // Filtering, rewrite and overrun.
    for (int a = 0; a < 4; a++) write(1'b0, a, 3);
    write(1'b1, 5, 3);
    write(1'b1, 15, 3);
    write(1'b1, 0, 1);
    write(1'b1, 1, 2);
    write(1'b1, 1, 3);
    write(1'b1, 2, 3);
    @(posedge clk); #1 in_direction = 1'b0;
    check("filter_not_busy", 32'(busy), 32'd0);
    check("filter_no_valid", 32'(out_valid), 32'd0);
    push_expected(m_rw);
    write(1'b1, 3, 0);
    @(posedge clk); #1;
    in_direction = 1'b1; in_addr = 4'd0; in_data = 2'd0;
    @(posedge clk); #1 in_direction = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_done("rewrite");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset while in OUTPUT.
    out_ready = 1'b0;
    load_all(m_basic);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rst_mid_valid_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("rst_mid");
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int a = 0; a < 3; a++) write(1'b1, a, m_basic[a]);
    @(posedge clk); #1 in_direction = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    check("partial_no_compute", 32'(seen), 32'd0);
    push_expected(m_basic);
    write(1'b1, 3, 0);
    @(posedge clk); #1 in_direction = 1'b0;
    check("after_rst_busy", 32'(busy), 32'd1);
    wait_done("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
